// File: rtl/alu_seq_responder.sv
// Handshaked multi-cycle ALU: single-cycle ops, bit-serial shifts and shift-add multiply.
// One request in flight; the response is held in DONE until the consumer takes it.
module alu_seq_responder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAnd = 4'b0100;
  localparam logic [3:0] OpOr  = 4'b0101;
  localparam logic [3:0] OpXor = 4'b0110;
  localparam logic [3:0] OpNor = 4'b0111;
  localparam logic [3:0] OpSlt = 4'b1010;
  localparam logic [3:0] OpSll = 4'b1000;
  localparam logic [3:0] OpSrl = 4'b1001;
  localparam logic [3:0] OpSra = 4'b1011;
  localparam logic [3:0] OpMul = 4'b1100;

  typedef enum logic [1:0] {StIdle, StShift, StMul, StDone} state_e;

  state_e           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_q;    // shift operand, or multiplicand during MUL
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             is_shift;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] acc_nxt;

  assign is_shift = (aluop == OpSll) || (aluop == OpSrl) || (aluop == OpSra);

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (aluop)
      OpAdd:   alu_res = a + b;
      OpSub:   alu_res = a - b;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpXor:   alu_res = a ^ b;
      OpNor:   alu_res = ~(a | b);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    shift_nxt = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    case (op_q)
      OpSll:   shift_nxt = {work_q[WIDTH-2:0], 1'b0};
      OpSrl:   shift_nxt = {1'b0, work_q[WIDTH-1:1]};
      default: ;
    endcase
  end

  assign acc_nxt = acc_q + (mplier_q[0] ? work_q : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
      op_q      <= '0;
      work_q    <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q     <= aluop;
            illegal  <= 1'b0;
            in_ready <= 1'b0;
            if (is_shift) begin
              if (b[4:0] != 5'd0) begin
                work_q  <= a;
                cnt_q   <= CW'(b[4:0]);
                state_q <= StShift;
              end else begin
                result    <= a;
                zero      <= (a == '0);
                out_valid <= 1'b1;
                state_q   <= StDone;
              end
            end else if (aluop == OpMul) begin
              work_q   <= a;
              mplier_q <= b;
              acc_q    <= '0;
              cnt_q    <= CW'(WIDTH);
              state_q  <= StMul;
            end else begin
              // Illegal ops fall through with alu_res == 0.
              result    <= alu_res;
              zero      <= (alu_res == '0);
              illegal   <= alu_ill;
              out_valid <= 1'b1;
              state_q   <= StDone;
            end
          end
        end
        StShift: begin
          work_q <= shift_nxt;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result    <= shift_nxt;
            zero      <= (shift_nxt == '0);
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StMul: begin
          acc_q    <= acc_nxt;
          work_q   <= {work_q[WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result    <= acc_nxt;
            zero      <= (acc_nxt == '0);
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq_responder.md
Name: alu_seq_responder

Overview:
- Handshaked, multi-cycle ALU execution unit for the MIPS datapath.
- Accepts an operation request (aluop, a, b) on a valid/ready input channel and returns result and zero on a valid/ready output channel.
- Single-cycle ops are computed on acceptance. Shifts iterate one bit per cycle. Multiply is shift-add over 32 cycles.
- Serves as the responder for a request-issuing sequencer or a self-checking vector driver.

Parameters:
- WIDTH, 32, operand and result width. Shift amount is b[4:0] and multiply iterates WIDTH cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- aluop  input  4  operation code.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; b[4:0] is the shift amount for shifts.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  high when result == 0.
- illegal  output  1  high when the accepted aluop is unassigned.

Behaviour:
- Opcodes:
  - 0000 add, 0010 sub, 0100 and, 0101 or, 0110 xor, 0111 nor, 1010 slt (signed).
  - 1000 sll, 1001 srl, 1011 sra (shift A by b[4:0]), 1100 mul (low WIDTH bits of a*b, unsigned).
  - All other codes are illegal.
- Reset (async, immediate): state IDLE; in_ready=1; out_valid=0; result=0; zero=1; illegal=0; all internal counters and accumulators cleared.
- States:
  - IDLE: in_ready=1. On in_valid (accept edge), latch aluop/a/b.
    - Single-cycle op or illegal op → DONE.
    - Shift with b[4:0]!=0 → SHIFT, counter loaded with b[4:0].
    - Shift with b[4:0]==0 → DONE with result=a.
    - mul → MUL, counter loaded with WIDTH.
  - SHIFT: each cycle, shift the working register by 1 and decrement the counter. When the counter reaches 1 on an edge → DONE.
    - sra replicates bit WIDTH-1; srl/sll fill with 0.
  - MUL: each cycle, if multiplier LSB=1 add the multiplicand to the accumulator; then multiplicand <<1, multiplier >>1, decrement the counter. Counter reaching 1 → DONE.
  - DONE: out_valid=1; result, zero and illegal stable. On out_ready → IDLE. With no out_ready, hold indefinitely.
- Latency (accept edge = edge 0):
  - Single-cycle, illegal and zero-shift: out_valid from edge 1.
  - Shift by n: out_valid from edge n+1.
  - mul: out_valid from edge WIDTH+1.
- in_ready=0 in SHIFT, MUL and DONE. A new request is accepted at the earliest on the edge after the output handshake (no same-cycle turnaround).
- Input signals are ignored while in_ready=0.
- add/sub wrap modulo 2^WIDTH; no overflow flag.
- slt yields 1 or 0, zero-extended.
- Illegal op: result=0, zero=1, illegal=1 for that response only. illegal is cleared on the next accept.
- zero is registered alongside result and always equals (result==0) while out_valid=1.
- result/zero/illegal keep their last value in IDLE until the next accept.
- Reset asserted mid-SHIFT, MUL or DONE aborts the operation: no response is produced and the state returns to IDLE.

Test Plan:
- add a=0x7FFFFFFF b=0x00000001 → out_valid at edge 1, result=0x80000000, zero=0. Then sub a=b=0x12345678 → result=0, zero=1.
- slt a=0xFFFFFFFF b=0x00000001 → result=1. nor a=0 b=0 → result=0xFFFFFFFF.
- sra a=0x80000000 b=0x1F → out_valid at edge 32, result=0xFFFFFFFF. srl with the same operands → 0x00000001. sll a=0x1 b=0x0 → result=0x1 at edge 1.
- mul a=0x00010000 b=0x00010000 → result=0, zero=1 at edge 33. mul a=0x3 b=0x5 → result=0xF.
- Hold out_ready=0 for 10 cycles after DONE with in_valid=1 and new operands applied → in_ready stays 0, result stable, no second accept. Releasing out_ready gives exactly one handshake, then in_ready=1.
- aluop=1111 → illegal=1, result=0. Also assert reset 5 cycles into mul a=0x3 b=0x5 → immediately out_valid=0, in_ready=1, result=0, and no stale response afterwards.
